int2float16_stream: RTL and testbench

//  Pipelined, parametrised integer/fixed-point to IEEE-754 binary16 converter for the input layer.

---
 rtl/int2float16_stream.sv | 158 +++++++++++++++
 tb/tb_int2float16_stream.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int2float16_stream.sv
//------------------------------------------------------------------------------
// Module  : int2float16_stream
// Brief   : Pipelined fixed-point to IEEE-754 binary16 converter with RNE
//           rounding, overflow/inexact flags and an fp16 pass-through mode.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module int2float16_stream #(
    parameter int IN_W     = 16,
    parameter int FRAC_W   = 0,
    parameter int SATURATE = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_signed,
    input  logic            in_cast,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data,
    output logic            out_ovf,
    output logic            out_inexact
);

    localparam int c_LW = IN_W + 10;
    localparam int c_PW = (IN_W < 16) ? IN_W : 16;

    logic w_adv;
    logic w_acc;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv & ~reset;
    assign w_acc    = in_valid & in_ready;

    // Stage valids; data registers below carry no reset since valid qualifies them.
    logic r_v0, r_v1, r_v2;

    logic [IN_W-1:0] r_d0;
    logic            r_sg0, r_cast0;

    logic            r_cast1, r_sign1;
    logic [IN_W-1:0] r_mag1;

    logic            r_cast2, r_sign2, r_zero2, r_g2, r_st2;
    logic [9:0]      r_mant2;
    logic [6:0]      r_exp2;
    logic [15:0]     r_pass2;

    // S1: sign and magnitude
    logic            w_s1_sign;
    logic [IN_W-1:0] w_s1_mag;

    assign w_s1_sign = r_cast0 & r_sg0 & r_d0[IN_W-1];
    assign w_s1_mag  = w_s1_sign ? (~r_d0 + 1'b1) : r_d0;

    // S2: leading-one detect and normalise
    logic [5:0]      w_p;
    logic [5:0]      w_shamt;
    logic [c_LW-2:0] w_norm;
    logic [9:0]      w_mant;
    logic            w_guard, w_sticky, w_zero;
    logic [6:0]      w_exp;

    always_comb begin
        w_p = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (r_mag1[i]) w_p = 6'(i);
        end
    end

    // The leading one is shifted out past the top of w_norm, leaving only fraction bits.
    assign w_zero   = ~|r_mag1;
    assign w_shamt  = 6'(IN_W - 1) - w_p;
    assign w_norm   = {r_mag1[IN_W-2:0], 10'b0} << w_shamt;
    assign w_mant   = w_norm[c_LW-2 -: 10];
    assign w_guard  = w_norm[c_LW-12];
    assign w_sticky = |w_norm[c_LW-13:0];
    assign w_exp    = 7'(w_p) + 7'd15 - 7'(FRAC_W);

    // S3: round to nearest even, overflow handling
    logic        w_up, w_carry, w_ovf;
    logic [9:0]  w_mant_r;
    logic [6:0]  w_exp_r;
    logic [15:0] w_res;
    logic        w_res_ovf, w_res_inex;

    assign w_up                = r_g2 & (r_st2 | r_mant2[0]);
    assign {w_carry, w_mant_r} = {1'b0, r_mant2} + 11'(w_up);
    assign w_exp_r             = r_exp2 + 7'(w_carry);
    assign w_ovf               = w_exp_r > 7'd30;

    always_comb begin
        w_res      = r_pass2;
        w_res_ovf  = 1'b0;
        w_res_inex = 1'b0;
        if (r_cast2) begin
            if (r_zero2) begin
                w_res = 16'h0000;
            end else if (w_ovf) begin
                w_res      = {r_sign2, (SATURATE != 0) ? 15'h7BFF : 15'h7C00};
                w_res_ovf  = 1'b1;
                w_res_inex = 1'b1;
            end else begin
                w_res      = {r_sign2, w_exp_r[4:0], w_mant_r};
                w_res_inex = r_g2 | r_st2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 16'h0000;
            out_ovf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (w_adv) begin
            r_v0      <= w_acc;
            r_v1      <= r_v0;
            r_v2      <= r_v1;
            out_valid <= r_v2;
            if (r_v2) begin
                out_data    <= w_res;
                out_ovf     <= w_res_ovf;
                out_inexact <= w_res_inex;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_d0    <= in_data;
            r_sg0   <= in_signed;
            r_cast0 <= in_cast;

            r_cast1 <= r_cast0;
            r_sign1 <= w_s1_sign;
            r_mag1  <= w_s1_mag;

            r_cast2 <= r_cast1;
            r_sign2 <= r_sign1;
            r_zero2 <= w_zero;
            r_mant2 <= w_mant;
            r_g2    <= w_guard;
            r_st2   <= w_sticky;
            r_exp2  <= w_exp;
            r_pass2 <= 16'(r_mag1[c_PW-1:0]);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int2float16_stream.sv
//------------------------------------------------------------------------------
// Module  : tb_int2float16_stream
// Brief   : Self-checking bench for int2float16_stream (three parameter sets).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_int2float16_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic        in_cast = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, in_ready_s, in_ready_f;
    logic        out_valid, out_valid_s, out_valid_f;
    logic [15:0] out_data, out_data_s, out_data_f;
    logic        out_ovf, out_ovf_s, out_ovf_f;
    logic        out_inexact, out_inexact_s, out_inexact_f;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    int2float16_stream #(.IN_W(16), .FRAC_W(0), .SATURATE(0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_signed(in_signed), .in_cast(in_cast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_inexact(out_inexact));

    int2float16_stream #(.IN_W(16), .FRAC_W(0), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_signed(in_signed), .in_cast(in_cast),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_ovf(out_ovf_s), .out_inexact(out_inexact_s));

    int2float16_stream #(.IN_W(16), .FRAC_W(8), .SATURATE(0)) u_frac (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_f),
        .in_data(in_data), .in_signed(in_signed), .in_cast(in_cast),
        .out_valid(out_valid_f), .out_ready(out_ready), .out_data(out_data_f),
        .out_ovf(out_ovf_f), .out_inexact(out_inexact_f));

    typedef struct { logic [15:0] d; bit sg; bit cast; } smp_t;
    typedef struct { logic [17:0] a; logic [17:0] b; logic [17:0] c; } obs_t;

    smp_t in_q[$];
    smp_t acc_q[$];
    obs_t got_q[$];
    bit   saw_full;
    int   hold_bad;

    // Reference: {ovf, inexact, fp16} from the numeric value of the sample.
    function automatic logic [17:0] model(input logic [15:0] d, input bit sg, input bit cast,
                                          input int frac, input bit sat);
        longint v, mag, m, r, half;
        int k, e;
        bit s, inex;
        if (!cast) return {2'b00, d};
        v    = sg ? longint'($signed(d)) : longint'(d);
        s    = v < 0;
        mag  = s ? -v : v;
        inex = 1'b0;
        if (mag == 0) return 18'h0;
        k = 0;
        while ((mag >> (k + 1)) != 0) k++;
        if (k >= 10) begin
            m = mag >> (k - 10);
            r = mag - (m << (k - 10));
            if (k > 10) begin
                half = longint'(1) << (k - 11);
                if (r > half || (r == half && m[0])) m++;
            end
            inex = (r != 0);
        end else begin
            m = mag << (10 - k);
        end
        e = k - frac + 15;
        if (m == 2048) begin
            m = 1024;
            e++;
        end
        if (e > 30) return {1'b1, 1'b1, s, sat ? 15'h7BFF : 15'h7C00};
        return {1'b0, inex, s, 5'(e), 10'(m)};
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            got_q.push_back('{a: {out_ovf, out_inexact, out_data},
                               b: {out_ovf_s, out_inexact_s, out_data_s},
                               c: {out_ovf_f, out_inexact_f, out_data_f}});
    end

    // Drives in_q, records accepted samples in acc_q; caller clears got_q.
    task automatic run_stream(input int stall_at, input int stall_len, input bit rnd_bp);
        int cyc = 0;
        int idx = 0;
        int n = in_q.size();
        bit have_prev = 1'b0;
        logic [17:0] prev = '0;
        acc_q.delete();
        saw_full = 1'b0;
        hold_bad = 0;
        while ((idx < n || got_q.size() < n) && cyc < 3000) begin
            if (idx < n) begin
                in_valid  = 1'b1;
                in_data   = in_q[idx].d;
                in_signed = in_q[idx].sg;
                in_cast   = in_q[idx].cast;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd_bp ? ($urandom_range(0, 3) != 0)
                               : !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc_q.push_back(in_q[idx]);
                idx++;
            end else if (in_valid) begin
                saw_full = 1'b1;
            end
            if (out_valid && !out_ready) begin
                if (have_prev && prev !== {out_ovf, out_inexact, out_data}) hold_bad++;
                prev      = {out_ovf, out_inexact, out_data};
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    function automatic smp_t rand_smp();
        smp_t s;
        s.d    = 16'($urandom) >> $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) s.d = -s.d;
        if ($urandom_range(0, 7) == 0) s.d = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h8000;
        s.sg   = $urandom_range(0, 1) != 0;
        s.cast = $urandom_range(0, 4) != 0;
        return s;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 16'h0 ||
            out_ovf !== 1'b0 || out_inexact !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b d=%h ovf=%b inx=%b, want all 0",
                     out_valid, in_ready, out_data, out_ovf, out_inexact);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] dv[11] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h8000, 16'd2049, 16'd2051,
                                16'd65519, 16'd65535, 16'hC500, 16'h0180, 16'h0001};
        bit          sv[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        bit          cv[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        logic [17:0] em[11] = '{18'h03C00, 18'h0BC00, 18'h00000, 18'h0F800, 18'h16800, 18'h16802,
                                18'h17BFF, 18'h37C00, 18'h0C500, 18'h05E00, 18'h03C00};
        in_q.delete();
        got_q.delete();
        for (int i = 0; i < 11; i++) in_q.push_back('{d: dv[i], sg: sv[i], cast: cv[i]});
        run_stream(1000, 0, 1'b0);
        checks++;
        if (got_q.size() != 11) begin
            errors++;
            $display("FAIL directed_count: got %0d want 11", got_q.size());
        end
        for (int i = 0; i < 11 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].a !== em[i]) begin
                errors++;
                $display("FAIL directed_main[%0d]: got %h want %h", i, got_q[i].a, em[i]);
            end
            checks++;
            if (got_q[i].b !== model(dv[i], sv[i], cv[i], 0, 1'b1)) begin
                errors++;
                $display("FAIL directed_sat[%0d]: got %h want %h", i, got_q[i].b,
                         model(dv[i], sv[i], cv[i], 0, 1'b1));
            end
            checks++;
            if (got_q[i].c !== model(dv[i], sv[i], cv[i], 8, 1'b0)) begin
                errors++;
                $display("FAIL directed_frac[%0d]: got %h want %h", i, got_q[i].c,
                         model(dv[i], sv[i], cv[i], 8, 1'b0));
            end
        end
        if (got_q.size() == 11) begin
            checks++;
            if (got_q[7].b !== 18'h37BFF) begin
                errors++;
                $display("FAIL saturate_65535: got %h want 37bff", got_q[7].b);
            end
            checks++;
            if (got_q[9].c !== 18'h03E00 || got_q[10].c !== 18'h01C00 || got_q[8].c !== 18'h0C500) begin
                errors++;
                $display("FAIL frac8_consts: got %h %h %h want 03e00 01c00 0c500",
                         got_q[9].c, got_q[10].c, got_q[8].c);
            end
        end
    endtask

    task automatic test_random();
        in_q.delete();
        got_q.delete();
        for (int i = 0; i < 80; i++) in_q.push_back(rand_smp());
        run_stream(0, 0, 1'b1);
        checks++;
        if (got_q.size() != 80 || acc_q.size() != 80) begin
            errors++;
            $display("FAIL random_count: got %0d/%0d want 80", got_q.size(), acc_q.size());
        end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            checks++;
            if (got_q[i].a !== model(acc_q[i].d, acc_q[i].sg, acc_q[i].cast, 0, 1'b0) ||
                got_q[i].b !== model(acc_q[i].d, acc_q[i].sg, acc_q[i].cast, 0, 1'b1) ||
                got_q[i].c !== model(acc_q[i].d, acc_q[i].sg, acc_q[i].cast, 8, 1'b0)) begin
                errors++;
                $display("FAIL random[%0d] in=%h s=%b c=%b: got %h/%h/%h want %h/%h/%h", i,
                         acc_q[i].d, acc_q[i].sg, acc_q[i].cast, got_q[i].a, got_q[i].b, got_q[i].c,
                         model(acc_q[i].d, acc_q[i].sg, acc_q[i].cast, 0, 1'b0),
                         model(acc_q[i].d, acc_q[i].sg, acc_q[i].cast, 0, 1'b1),
                         model(acc_q[i].d, acc_q[i].sg, acc_q[i].cast, 8, 1'b0));
            end
        end
    endtask

    task automatic test_back_to_back();
        smp_t s;
        in_q.delete();
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            s      = rand_smp();
            s.cast = i[0];
            in_q.push_back(s);
        end
        run_stream(1000, 0, 1'b0);
        checks++;
        if (saw_full || got_q.size() != 16) begin
            errors++;
            $display("FAIL b2b_throughput: stalled=%b got %0d want stalled=0 count 16",
                     saw_full, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 16; i++) begin
            checks++;
            if (got_q[i].a !== model(in_q[i].d, in_q[i].sg, in_q[i].cast, 0, 1'b0)) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h want %h", i, got_q[i].a,
                         model(in_q[i].d, in_q[i].sg, in_q[i].cast, 0, 1'b0));
            end
        end
    endtask

    task automatic test_backpressure();
        in_q.delete();
        got_q.delete();
        for (int i = 0; i < 8; i++) in_q.push_back('{d: 16'(1000 * i + 3), sg: 1'b0, cast: 1'b1});
        run_stream(4, 5, 1'b0);
        checks++;
        if (!saw_full || hold_bad != 0) begin
            errors++;
            $display("FAIL bp_stall: ready_dropped=%b hold_changes=%0d want 1 and 0", saw_full, hold_bad);
        end
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d want 8", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            checks++;
            if (got_q[i].a !== model(in_q[i].d, 1'b0, 1'b1, 0, 1'b0)) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i].a,
                         model(in_q[i].d, 1'b0, 1'b1, 0, 1'b0));
            end
        end
    endtask

    task automatic test_reset_flight();
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_data   = 16'(7 + i);
            in_signed = 1'b0;
            in_cast   = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        in_q.delete();
        in_q.push_back('{d: 16'h0400, sg: 1'b0, cast: 1'b1});
        in_q.push_back('{d: 16'hFFFE, sg: 1'b1, cast: 1'b1});
        run_stream(1000, 0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 3 - 1) begin
            errors++;
            $display("FAIL flush_count: got %0d want 2", got_q.size());
        end
        if (got_q.size() >= 2) begin
            checks++;
            if (got_q[0].a !== 18'h06400 || got_q[1].a !== 18'h0C000) begin
                errors++;
                $display("FAIL flush_values: got %h %h want 06400 0c000", got_q[0].a, got_q[1].a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
